// File: rtl/clarvi_mem_arbiter_pkg.sv
// Shared types for the CLARVI fetch/data memory arbiter: FSM state and the
// owner tag carried alongside each outstanding memory read.
package clarvi_mem_arbiter_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    DATA_LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic is_data;
  } resp_tag_t;

  function automatic resp_tag_t make_tag(input logic valid, input logic is_data);
    resp_tag_t t;
    t.valid   = valid;
    t.is_data = is_data;
    return t;
  endfunction

endpackage

// File: rtl/clarvi_mem_arbiter_if.sv
// Bundle of the fetch port, MMU data port and shared byte-wide memory port.
// Handshake: a requester holds its *_enable (and address/data) stable until
// the arbiter raises its *_grant, which is combinational in that same cycle;
// a transfer happens exactly in a cycle where enable and grant are both 1.
// Read responses carry no backpressure: *_read_valid is a one-cycle strobe.
interface clarvi_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic                  fetch_read_enable;
  logic                  fetch_grant;
  logic                  fetch_read_valid;
  logic [7:0]            fetch_read_data;

  logic [ADDR_WIDTH-1:0] data_address;
  logic                  data_read_enable;
  logic                  data_write_enable;
  logic                  data_byte_enable;
  logic [7:0]            data_write_data;
  logic                  data_burst_last;
  logic                  data_grant;
  logic                  data_read_valid;
  logic [7:0]            data_read_data;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_byte_enable;
  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [7:0]            mem_write_data;
  logic [7:0]            mem_read_data;

  // Arbiter side.
  modport slave (
    input  fetch_address, fetch_read_enable,
    output fetch_grant, fetch_read_valid, fetch_read_data,
    input  data_address, data_read_enable, data_write_enable, data_byte_enable,
    input  data_write_data, data_burst_last,
    output data_grant, data_read_valid, data_read_data,
    output mem_address, mem_byte_enable, mem_read_enable, mem_write_enable,
    output mem_write_data,
    input  mem_read_data
  );

  // Requesters plus memory side.
  modport master (
    output fetch_address, fetch_read_enable,
    input  fetch_grant, fetch_read_valid, fetch_read_data,
    output data_address, data_read_enable, data_write_enable, data_byte_enable,
    output data_write_data, data_burst_last,
    input  data_grant, data_read_valid, data_read_data,
    input  mem_address, mem_byte_enable, mem_read_enable, mem_write_enable,
    input  mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/clarvi_resp_tag_pipe.sv
// Fixed-latency delay line that carries the owner tag of each memory access
// so it emerges in the cycle the memory returns that access's read byte.
module clarvi_resp_tag_pipe
  import clarvi_mem_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  resp_tag_t tag_i,
  output resp_tag_t tag_o
);

  resp_tag_t stage_q [READ_LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < READ_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Arbitrates the CLARVI instruction fetch and MMU data ports onto one
// byte-wide memory; data has priority, bounded by a starvation streak limit.
module clarvi_mem_arbiter
  import clarvi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 14,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_DATA_STREAK = 8,
  localparam int STREAK_W       = $clog2(MAX_DATA_STREAK + 1)
) (
  input  logic                clock,
  input  logic                reset,
  clarvi_mem_arbiter_if.slave bus,
  output arb_state_t          state_o,
  output logic [STREAK_W-1:0] streak_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                data_req, fetch_gnt, data_gnt, data_is_write;
  resp_tag_t           push_tag, pop_tag;

  assign data_req      = bus.data_read_enable | bus.data_write_enable;
  assign data_is_write = bus.data_write_enable;

  // Grants are suppressed during reset so nothing reaches memory that cycle.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!reset) begin
      if (state_q == DATA_LOCK) begin
        data_gnt = data_req;
      end else if (bus.fetch_read_enable && (!data_req || streak_q == STREAK_MAX)) begin
        fetch_gnt = 1'b1;
      end else begin
        data_gnt = data_req;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (data_gnt) state_d = bus.data_burst_last ? IDLE : DATA_LOCK;
    if (state_q == IDLE) begin
      if (fetch_gnt || !bus.fetch_read_enable) begin
        streak_d = '0;
      end else if (data_gnt && streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    bus.mem_address      = '0;
    bus.mem_byte_enable  = 1'b0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_write_data   = '0;
    if (fetch_gnt) begin
      bus.mem_address     = bus.fetch_address;
      bus.mem_byte_enable = 1'b1;
      bus.mem_read_enable = 1'b1;
    end else if (data_gnt) begin
      // Read+write together is a write; the read half is dropped.
      bus.mem_address      = bus.data_address;
      bus.mem_byte_enable  = bus.data_byte_enable;
      bus.mem_read_enable  = bus.data_read_enable & ~data_is_write;
      bus.mem_write_enable = data_is_write;
      bus.mem_write_data   = bus.data_write_data;
    end
  end

  assign push_tag = make_tag(fetch_gnt | (data_gnt & bus.data_read_enable & ~data_is_write),
                             data_gnt);

  clarvi_resp_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .tag_i (push_tag),
    .tag_o (pop_tag)
  );

  assign bus.fetch_grant      = fetch_gnt;
  assign bus.data_grant       = data_gnt;
  assign bus.fetch_read_valid = ~reset & pop_tag.valid & ~pop_tag.is_data;
  assign bus.data_read_valid  = ~reset & pop_tag.valid &  pop_tag.is_data;
  assign bus.fetch_read_data  = bus.fetch_read_valid ? bus.mem_read_data : 8'h00;
  assign bus.data_read_data   = bus.data_read_valid  ? bus.mem_read_data : 8'h00;

  assign state_o  = state_q;
  assign streak_o = streak_q;

endmodule

// File: doc/clarvi_mem_arbiter.md
CLARVI_MEM_ARBITER -- requirements
Module: clarvi_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, is the byte address width of the shared memory port.
REQ-002 Parameter READ_LATENCY, default 1, is the fixed cycles from mem_read_enable to valid mem_read_data; legal range 1..4.
REQ-003 Parameter MAX_DATA_STREAK, default 8, is the maximum consecutive unlocked data grants while fetch waits.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 fetch_address  in  ADDR_WIDTH  instruction byte address.
REQ-008 fetch_read_enable  in  1  fetch read request; held until granted.
REQ-009 fetch_grant  out  1  fetch request accepted this cycle.
REQ-010 fetch_read_valid / fetch_read_data  out  1 / 8  fetch response strobe and byte.
REQ-011 data_address  in  ADDR_WIDTH  MMU byte address.
REQ-012 data_read_enable, data_write_enable, data_byte_enable  in  1 each  MMU request and byte lane enable.
REQ-013 data_write_data  in  8  store byte.
REQ-014 data_burst_last  in  1  this byte ends the MMU multi-byte access.
REQ-015 data_grant  out  1  data request accepted this cycle.
REQ-016 data_read_valid / data_read_data  out  1 / 8  data response strobe and byte.
REQ-017 mem_address, mem_byte_enable, mem_read_enable, mem_write_enable, mem_write_data  out  ADDR_WIDTH,1,1,1,8  shared memory port.
REQ-018 mem_read_data  in  8  memory read byte.

Function
REQ-019 Grants SHALL be combinational in the request cycle; the granted requester's address/enables SHALL drive mem_* that same cycle; ungranted cycles drive mem_read_enable = mem_write_enable = 0.
REQ-020 At most one of fetch_grant, data_grant SHALL be 1 per cycle.
REQ-021 Fetch accesses SHALL drive mem_byte_enable = 1 and mem_write_enable = 0.
REQ-022 Data request with both read and write enables SHALL be treated as a write; no response generated.
REQ-023 FSM states IDLE and DATA_LOCK; reset state IDLE.
REQ-024 IDLE: data wins over fetch unless streak == MAX_DATA_STREAK and fetch_read_enable, then fetch wins.
REQ-025 IDLE -> DATA_LOCK on a data grant with data_burst_last = 0.
REQ-026 DATA_LOCK: only data may be granted; fetch waits even if data is idle that cycle.
REQ-027 DATA_LOCK -> IDLE on a data grant with data_burst_last = 1.
REQ-028 Streak counter SHALL increment on each IDLE-state data grant while fetch_read_enable = 1, saturate at MAX_DATA_STREAK, clear on fetch grant or when fetch_read_enable = 0; unchanged in DATA_LOCK.
REQ-029 Each granted read SHALL push an owner tag {valid, is_data} into a READ_LATENCY-deep delay line; writes push valid = 0.
REQ-030 When the tag leaving the delay line is valid, the owner's *_read_valid SHALL pulse 1 cycle and *_read_data = mem_read_data; the other strobe stays 0.
REQ-031 Responses SHALL return in grant order, one per cycle, sustaining back-to-back reads at full rate.
REQ-032 Read data outputs SHALL be 0 when their strobe is 0.

Reset
REQ-033 Reset SHALL force IDLE, streak 0, all tags invalid; all grant, enable and valid outputs 0 in the cycle reset is asserted.
REQ-034 Reads in flight at reset SHALL be discarded; no response strobe for them after reset deasserts.
REQ-035 Reset mid-DATA_LOCK SHALL release the lock; first post-reset cycle arbitrates per REQ-024.

Structure
REQ-036 Enum arb_state_t {IDLE, DATA_LOCK} and typedef resp_tag_t {valid, is_data} SHALL live in the shared clarvi package.
REQ-037 The tag delay line SHALL be a sub-module clarvi_resp_tag_pipe parameterised by READ_LATENCY.

Verification
REQ-038 Fetch 0x0100 and data read 0x0200 in same IDLE cycle -> data_grant=1, mem_address=0x0200; data_read_valid after READ_LATENCY cycles, fetch granted next cycle.
REQ-039 8-byte data load 0x0040..0x0047, burst_last only on byte 8, fetch requesting throughout, data idle one mid-burst cycle -> fetch_grant stays 0 until the cycle after byte 8.
REQ-040 Data single-byte reads continuously with fetch_read_enable=1, MAX_DATA_STREAK=8 -> 9th cycle fetch_grant=1, then streak restarts at 0.
REQ-041 Alternating fetch/data reads every cycle, READ_LATENCY=2 -> responses strobe to correct owner in order, no gaps, data bytes match memory model.
REQ-042 Data write 0x0300 value 0xA5 with read also set -> mem_write_enable=1, mem_read_enable=0, no response strobe.
REQ-043 Reset asserted one cycle after a granted read inside DATA_LOCK -> no read_valid afterwards, state IDLE, fetch granted first cycle after reset if data idle.
